mem_xfer_scheduler: RTL and testbench

Sequences cache-line transfers between the dcache/icache SRAMs and external memory by driving the MemoryController command port (ce/we/cacheID/sramAddr/extAddr, busy/progress). Accepts transfer requests from two requesters (0 = dcache miss/writeback unit, 1 = icache fill unit), queues them per requester, and arbitrates round-robin. Issues one command at a time and reports completion to the owning requester. Sits between the core's cache-miss logic and memc, replacing the core's direct OUT_MC_* drive.

---
 rtl/mem_xfer_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_mem_xfer_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_scheduler.sv
// mem_xfer_scheduler: queues cache-line transfer requests from dcache (0)
// and icache (1) and issues them round-robin, one at a time, to memc.
// Ports: clk/rst (async, active-high); IN_REQ_* per-requester push port
// with OUT_REQ_ready; OUT_REQ_done/active/progress completion status;
// OUT_MC_* command to memc with IN_MC_busy/IN_MC_progress back;
// OUT_PERF_* counters built only with `define PERF_CNTRS_EN (else 0).
module mem_xfer_scheduler #(
  parameter int QUEUE_DEPTH = 2,
  parameter int SRAM_AW     = 10,
  parameter int EXT_AW      = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            IN_REQ_valid,
  input  logic [1:0]            IN_REQ_we,
  input  logic [2*SRAM_AW-1:0]  IN_REQ_sramAddr,
  input  logic [2*EXT_AW-1:0]   IN_REQ_extAddr,
  output logic [1:0]            OUT_REQ_ready,
  output logic [1:0]            OUT_REQ_done,
  output logic [1:0]            OUT_REQ_active,
  output logic [SRAM_AW-1:0]    OUT_REQ_progress,
  output logic                  OUT_MC_ce,
  output logic                  OUT_MC_we,
  output logic                  OUT_MC_cacheID,
  output logic [SRAM_AW-1:0]    OUT_MC_sramAddr,
  output logic [EXT_AW-1:0]     OUT_MC_extAddr,
  input  logic [SRAM_AW-1:0]    IN_MC_progress,
  input  logic                  IN_MC_busy,
  output logic [31:0]           OUT_PERF_done0,
  output logic [31:0]           OUT_PERF_done1,
  output logic [31:0]           OUT_PERF_stall
);

  localparam int EW = 1 + SRAM_AW + EXT_AW;
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(QUEUE_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t state_q, state_nxt;

  logic          owner_q;
  logic          rr_q;
  logic          winner;
  logic          mc_we_q;
  logic [SRAM_AW-1:0] mc_sram_q;
  logic [EXT_AW-1:0]  mc_ext_q;

  logic [EW-1:0] q_mem [2][QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr [2];
  logic [PW-1:0] wr_ptr [2];
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] cnt_nxt [2];
  logic [EW-1:0] in_ent [2];
  logic [EW-1:0] head [2];
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    nonempty;
  logic [1:0]    ready_q;
  logic [1:0]    owner_oh;
  logic          done_evt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      push[i]     = IN_REQ_valid[i] & ready_q[i];
      pop[i]      = (state_q == ISSUE) && (owner_q == 1'(i));
      nonempty[i] = (cnt[i] != '0);
      cnt_nxt[i]  = cnt[i] + CW'(push[i]) - CW'(pop[i]);
      in_ent[i]   = {IN_REQ_we[i],
                     IN_REQ_sramAddr[i*SRAM_AW +: SRAM_AW],
                     IN_REQ_extAddr[i*EXT_AW +: EXT_AW]};
      head[i]     = q_mem[i][rd_ptr[i]];
    end
  end

  // rr pointer wins when it has work, otherwise the other side
  assign winner = nonempty[rr_q] ? rr_q : ~rr_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) q_mem[i][wr_ptr[i]] <= in_ent[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      ready_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        cnt[i]     <= cnt_nxt[i];
        ready_q[i] <= (cnt_nxt[i] < DEPTH_C);
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:      if (|nonempty && !IN_MC_busy) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_ACK;
      WAIT_ACK:  if (IN_MC_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!IN_MC_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      mc_we_q   <= 1'b0;
      mc_sram_q <= '0;
      mc_ext_q  <= '0;
    end else begin
      state_q <= state_nxt;
      // latch the head now; it stays put through ISSUE since
      // pushes only touch the tail of a non-empty queue
      if (state_q == IDLE && state_nxt == ISSUE) begin
        owner_q <= winner;
        {mc_we_q, mc_sram_q, mc_ext_q} <= head[winner];
      end
      if (state_q == ISSUE) rr_q <= ~owner_q;
    end
  end

  assign owner_oh = {owner_q, ~owner_q};
  assign done_evt = (state_q == WAIT_DONE) && !IN_MC_busy;

  assign OUT_REQ_ready    = ready_q;
  assign OUT_REQ_done     = done_evt ? owner_oh : 2'b00;
  assign OUT_REQ_active   =
    (state_q != IDLE && !done_evt) ? owner_oh : 2'b00;
  assign OUT_REQ_progress =
    (|OUT_REQ_active) ? IN_MC_progress : '0;

  assign OUT_MC_ce       = (state_q == ISSUE);
  assign OUT_MC_we       = mc_we_q;
  assign OUT_MC_cacheID  = owner_q;
  assign OUT_MC_sramAddr = mc_sram_q;
  assign OUT_MC_extAddr  = mc_ext_q;

`ifdef PERF_CNTRS_EN
  logic [31:0] perf_d0_q;
  logic [31:0] perf_d1_q;
  logic [31:0] perf_st_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_d0_q <= '0;
      perf_d1_q <= '0;
      perf_st_q <= '0;
    end else begin
      if (OUT_REQ_done[0]) perf_d0_q <= perf_d0_q + 32'd1;
      if (OUT_REQ_done[1]) perf_d1_q <= perf_d1_q + 32'd1;
      if (|nonempty && state_q != IDLE)
        perf_st_q <= perf_st_q + 32'd1;
    end
  end

  assign OUT_PERF_done0 = perf_d0_q;
  assign OUT_PERF_done1 = perf_d1_q;
  assign OUT_PERF_stall = perf_st_q;
`else
  assign OUT_PERF_done0 = '0;
  assign OUT_PERF_done1 = '0;
  assign OUT_PERF_stall = '0;
`endif

endmodule

// File: tb/tb_mem_xfer_scheduler.sv
// tb_mem_xfer_scheduler: directed bench for mem_xfer_scheduler with a
// small memc busy model and a command/done monitor.
module tb_mem_xfer_scheduler;

  localparam int SA = 10;
  localparam int EA = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    IN_REQ_valid;
  logic [1:0]    IN_REQ_we;
  logic [2*SA-1:0] IN_REQ_sramAddr;
  logic [2*EA-1:0] IN_REQ_extAddr;
  logic [1:0]    OUT_REQ_ready;
  logic [1:0]    OUT_REQ_done;
  logic [1:0]    OUT_REQ_active;
  logic [SA-1:0] OUT_REQ_progress;
  logic          OUT_MC_ce;
  logic          OUT_MC_we;
  logic          OUT_MC_cacheID;
  logic [SA-1:0] OUT_MC_sramAddr;
  logic [EA-1:0] OUT_MC_extAddr;
  logic [SA-1:0] IN_MC_progress;
  logic          IN_MC_busy;
  logic [31:0]   OUT_PERF_done0;
  logic [31:0]   OUT_PERF_done1;
  logic [31:0]   OUT_PERF_stall;

  mem_xfer_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .IN_REQ_valid     (IN_REQ_valid),
    .IN_REQ_we        (IN_REQ_we),
    .IN_REQ_sramAddr  (IN_REQ_sramAddr),
    .IN_REQ_extAddr   (IN_REQ_extAddr),
    .OUT_REQ_ready    (OUT_REQ_ready),
    .OUT_REQ_done     (OUT_REQ_done),
    .OUT_REQ_active   (OUT_REQ_active),
    .OUT_REQ_progress (OUT_REQ_progress),
    .OUT_MC_ce        (OUT_MC_ce),
    .OUT_MC_we        (OUT_MC_we),
    .OUT_MC_cacheID   (OUT_MC_cacheID),
    .OUT_MC_sramAddr  (OUT_MC_sramAddr),
    .OUT_MC_extAddr   (OUT_MC_extAddr),
    .IN_MC_progress   (IN_MC_progress),
    .IN_MC_busy       (IN_MC_busy),
    .OUT_PERF_done0   (OUT_PERF_done0),
    .OUT_PERF_done1   (OUT_PERF_done1),
    .OUT_PERF_stall   (OUT_PERF_stall)
  );

  always #5 clk = ~clk;

  // memc model: busy rises the cycle after ce, lasts busy_len cycles
  int   busy_len;
  int   busy_cnt;
  logic mbusy;
  logic foreign_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mbusy    <= 1'b0;
      busy_cnt <= 0;
    end else if (OUT_MC_ce) begin
      mbusy    <= 1'b1;
      busy_cnt <= busy_len - 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      mbusy <= 1'b0;
    end
  end

  assign IN_MC_busy = mbusy | foreign_busy;

  int unsigned log_ext[$];
  int unsigned log_sram[$];
  bit          log_cid[$];
  bit          log_we[$];
  int          nd0 = 0;
  int          nd1 = 0;

  always @(negedge clk) begin
    if (OUT_MC_ce) begin
      log_ext.push_back(OUT_MC_extAddr);
      log_sram.push_back(OUT_MC_sramAddr);
      log_cid.push_back(OUT_MC_cacheID);
      log_we.push_back(OUT_MC_we);
    end
    if (OUT_REQ_done[0]) nd0 <= nd0 + 1;
    if (OUT_REQ_done[1]) nd1 <= nd1 + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input bit we,
                      input int sa, input int ea);
    IN_REQ_valid[r] = 1'b1;
    IN_REQ_we[r] = we;
    IN_REQ_sramAddr[r*SA +: SA] = sa[SA-1:0];
    IN_REQ_extAddr[r*EA +: EA] = ea[EA-1:0];
    @(negedge clk);
    IN_REQ_valid = '0;
  endtask

  task automatic wait_ce(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (OUT_MC_ce) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, seen, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int base;
  int b0;
  int b1;

  initial begin
    rst = 1'b1;
    IN_REQ_valid = '0;
    IN_REQ_we = '0;
    IN_REQ_sramAddr = '0;
    IN_REQ_extAddr = '0;
    IN_MC_progress = 10'h015;
    foreign_busy = 1'b0;
    busy_len = 5;
    repeat (2) @(negedge clk);
    chk("rst_ce", OUT_MC_ce, 1'b0);
    chk("rst_ext", OUT_MC_extAddr, 0);
    chk("rst_sram", OUT_MC_sramAddr, 0);
    chk("rst_done", OUT_REQ_done, 2'b00);
    chk("rst_active", OUT_REQ_active, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", OUT_REQ_ready, 2'b11);

    // single fill
    base = log_ext.size();
    b0 = nd0;
    b1 = nd1;
    push(0, 1'b0, 'h040, 'h100);
    wait_ce("t1_ce_seen");
    @(negedge clk);
    chk("t1_active", OUT_REQ_active, 2'b01);
    chk("t1_progress", OUT_REQ_progress, 10'h015);
    repeat (20) @(negedge clk);
    chk("t1_ncmd", log_ext.size() - base, 1);
    chk("t1_cid", log_cid[base], 1'b0);
    chk("t1_we", log_we[base], 1'b0);
    chk("t1_sram", log_sram[base], 'h040);
    chk("t1_ext", log_ext[base], 'h100);
    chk("t1_done0", nd0 - b0, 1);
    chk("t1_done1", nd1 - b1, 0);
    chk("t1_idle_act", OUT_REQ_active, 2'b00);

    // contention from reset: 0x10(0), 0x20(1), 0x30(0)
    do_reset();
    base = log_ext.size();
    b0 = nd0;
    b1 = nd1;
    IN_REQ_valid = 2'b11;
    IN_REQ_we = 2'b00;
    IN_REQ_sramAddr = {10'h002, 10'h001};
    IN_REQ_extAddr = {30'h20, 30'h10};
    @(negedge clk);
    IN_REQ_valid = 2'b01;
    IN_REQ_sramAddr[SA-1:0] = 10'h003;
    IN_REQ_extAddr[EA-1:0] = 30'h30;
    @(negedge clk);
    IN_REQ_valid = 2'b00;
    repeat (60) @(negedge clk);
    chk("t2_ncmd", log_ext.size() - base, 3);
    chk("t2_ext0", log_ext[base], 'h10);
    chk("t2_cid0", log_cid[base], 1'b0);
    chk("t2_ext1", log_ext[base+1], 'h20);
    chk("t2_cid1", log_cid[base+1], 1'b1);
    chk("t2_ext2", log_ext[base+2], 'h30);
    chk("t2_cid2", log_cid[base+2], 1'b0);
    chk("t2_done0", nd0 - b0, 2);
    chk("t2_done1", nd1 - b1, 1);

    // full queue on requester 1
    do_reset();
    base = log_ext.size();
    foreign_busy = 1'b1;
    IN_REQ_valid = 2'b10;
    IN_REQ_sramAddr[SA +: SA] = 10'h011;
    IN_REQ_extAddr[EA +: EA] = 30'hA1;
    chk("t3_rdy_a", OUT_REQ_ready[1], 1'b1);
    @(negedge clk);
    IN_REQ_extAddr[EA +: EA] = 30'hA2;
    chk("t3_rdy_b", OUT_REQ_ready[1], 1'b1);
    @(negedge clk);
    IN_REQ_extAddr[EA +: EA] = 30'hA3;
    chk("t3_rdy_c", OUT_REQ_ready[1], 1'b0);
    @(negedge clk);
    IN_REQ_valid = 2'b00;
    chk("t3_rdy_d", OUT_REQ_ready[1], 1'b0);
    foreign_busy = 1'b0;
    @(negedge clk);
    chk("t3_ce", OUT_MC_ce, 1'b1);
    chk("t3_rdy_pop", OUT_REQ_ready[1], 1'b0);
    @(negedge clk);
    chk("t3_rdy_up", OUT_REQ_ready[1], 1'b1);
    repeat (40) @(negedge clk);
    chk("t3_ncmd", log_ext.size() - base, 2);
    chk("t3_ext0", log_ext[base], 'hA1);
    chk("t3_ext1", log_ext[base+1], 'hA2);

    // memc busy from a foreign transfer
    do_reset();
    base = log_ext.size();
    foreign_busy = 1'b1;
    push(0, 1'b1, 'h005, 'h55);
    repeat (5) @(negedge clk);
    chk("t4_no_ce", log_ext.size() - base, 0);
    foreign_busy = 1'b0;
    chk("t4_ce_lo", OUT_MC_ce, 1'b0);
    @(negedge clk);
    chk("t4_ce_hi", OUT_MC_ce, 1'b1);
    chk("t4_we", OUT_MC_we, 1'b1);
    repeat (20) @(negedge clk);

    // reset during WAIT_DONE
    do_reset();
    busy_len = 8;
    base = log_ext.size();
    b1 = nd1;
    push(1, 1'b0, 'h007, 'h77);
    wait_ce("t5_ce_seen");
    repeat (2) @(negedge clk);
    chk("t5_act_pre", OUT_REQ_active, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("t5_act", OUT_REQ_active, 2'b00);
    chk("t5_ce", OUT_MC_ce, 1'b0);
    chk("t5_done", OUT_REQ_done, 2'b00);
    chk("t5_ext", OUT_MC_extAddr, 0);
    chk("t5_cid", OUT_MC_cacheID, 1'b0);
    chk("t5_prog", OUT_REQ_progress, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ready", OUT_REQ_ready, 2'b11);
    repeat (20) @(negedge clk);
    chk("t5_ncmd", log_ext.size() - base, 1);
    chk("t5_nodone", nd1 - b1, 0);

    // perf counters: 3 for req0, 2 for req1
    do_reset();
    busy_len = 3;
    b0 = nd0;
    b1 = nd1;
    for (int k = 0; k < 3; k++) begin
      push(0, 1'b0, k, 'h200 + k);
      repeat (15) @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      push(1, 1'b0, k, 'h300 + k);
      repeat (15) @(negedge clk);
    end
    chk("t6_done0", nd0 - b0, 3);
    chk("t6_done1", nd1 - b1, 2);
`ifdef PERF_CNTRS_EN
    chk("t6_perf0", OUT_PERF_done0, 3);
    chk("t6_perf1", OUT_PERF_done1, 2);
    chk("t6_stall", OUT_PERF_stall, 5);
`else
    chk("t6_perf0", OUT_PERF_done0, 0);
    chk("t6_perf1", OUT_PERF_done1, 0);
    chk("t6_stall", OUT_PERF_stall, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
